// File: rtl/io_port_bridge.sv
// Processor I/O bridge: an input FIFO from an external valid/ready producer to the CPU,
// and a single-entry output holding register from the CPU to an external valid/ready consumer.
module io_port_bridge #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         CPUOut,
  input  logic                     CPUWrite,
  input  logic                     CPURead,
  output logic [WIDTH-1:0]         IOIn,
  output logic                     InAvail,
  output logic [$clog2(DEPTH):0]   InCount,
  output logic                     OutBusy,
  input  logic [WIDTH-1:0]         ExtInData,
  input  logic                     ExtInValid,
  output logic                     ExtInReady,
  output logic [WIDTH-1:0]         ExtOutData,
  output logic                     ExtOutValid,
  input  logic                     ExtOutReady,
  input  logic                     ErrClear,
  output logic                     Overflow,
  output logic                     Underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] wr_en;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  out_state_t       out_state_q, out_state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic push, pop, fifo_empty;
  logic overflow_set, underflow_set;

  assign fifo_empty = (count_q == '0);
  // Readiness comes from the registered count only, so a pop never frees a slot for the same edge.
  assign ExtInReady = (count_q < CW'(DEPTH));
  assign push       = ExtInValid && ExtInReady;
  assign pop        = CPURead && !fifo_empty;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_ptr_q == PW'(gi));
    end
  endgenerate

  // Storage carries no reset; the count alone decides which entries are live.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) mem_q[i] <= ExtInData;
    end
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    out_state_d   = out_state_q;
    out_data_d    = out_data_q;
    overflow_set  = 1'b0;
    underflow_set = CPURead && fifo_empty;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    case (out_state_q)
      OUT_EMPTY: begin
        if (CPUWrite) begin
          out_data_d  = CPUOut;
          out_state_d = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (ExtOutReady) begin
          if (CPUWrite) out_data_d = CPUOut;
          else          out_state_d = OUT_EMPTY;
        end else if (CPUWrite) begin
          overflow_set = 1'b1;
        end
      end
      default: out_state_d = OUT_EMPTY;
    endcase

    overflow_d  = overflow_set  || (overflow_q  && !ErrClear);
    underflow_d = underflow_set || (underflow_q && !ErrClear);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_state_q <= OUT_EMPTY;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_state_q <= out_state_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign IOIn        = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign InAvail     = !fifo_empty;
  assign InCount     = count_q;
  assign ExtOutData  = out_data_q;
  assign ExtOutValid = (out_state_q == OUT_FULL);
  assign OutBusy     = ExtOutValid;
  assign Overflow    = overflow_q;
  assign Underflow   = underflow_q;

endmodule

// File: doc/io_port_bridge.md
IO_PORT_BRIDGE -- requirements
Module: io_port_bridge

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data word width for all data ports.
REQ-002 SHALL have parameter DEPTH, default 4: input FIFO entry count, power of two, minimum 2.
REQ-003 SHALL have port CLK  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port CPUOut  input  WIDTH  word from the processor output port.
REQ-006 SHALL have port CPUWrite  input  1  one-cycle strobe: CPUOut is valid this cycle.
REQ-007 SHALL have port CPURead  input  1  one-cycle strobe: processor consumes IOIn this cycle.
REQ-008 SHALL have port IOIn  output  WIDTH  input FIFO head word to the processor input port.
REQ-009 SHALL have port InAvail  output  1  input FIFO non-empty.
REQ-010 SHALL have port InCount  output  $clog2(DEPTH)+1  input FIFO occupancy.
REQ-011 SHALL have port OutBusy  output  1  output holding register full.
REQ-012 SHALL have port ExtInData  input  WIDTH  external producer data.
REQ-013 SHALL have port ExtInValid  input  1  external producer valid.
REQ-014 SHALL have port ExtInReady  output  1  bridge accepts external word.
REQ-015 SHALL have port ExtOutData  output  WIDTH  word to external consumer.
REQ-016 SHALL have port ExtOutValid  output  1  ExtOutData valid.
REQ-017 SHALL have port ExtOutReady  input  1  external consumer accepts.
REQ-018 SHALL have port ErrClear  input  1  synchronous clear of sticky error flags.
REQ-019 SHALL have port Overflow  output  1  sticky: CPUWrite dropped.
REQ-020 SHALL have port Underflow  output  1  sticky: CPURead with empty FIFO.

Function
REQ-021 SHALL push ExtInData into the input FIFO on a rising edge where ExtInValid and ExtInReady are both 1.
REQ-022 SHALL drive ExtInReady = 1 exactly when InCount < DEPTH, decoded from registered count; a pop in a full cycle SHALL NOT enable a same-cycle push.
REQ-023 SHALL drive IOIn combinationally from the FIFO head entry, and drive IOIn to 0 when InCount = 0.
REQ-024 SHALL pop the head on a rising edge where CPURead = 1 and InCount > 0; the next word appears on IOIn the following cycle.
REQ-025 SHALL, on simultaneous push and pop with 0 < InCount < DEPTH, leave InCount unchanged and preserve FIFO order.
REQ-026 SHALL wrap read and write pointers modulo DEPTH with no lost or duplicated word.
REQ-027 SHALL, on CPURead with InCount = 0, leave FIFO state unchanged and set Underflow the next edge.
REQ-028 SHALL implement an output FSM with states EMPTY (ExtOutValid=0) and FULL (ExtOutValid=1); ExtOutData SHALL be the holding register.
REQ-029 SHALL, in EMPTY on CPUWrite, load CPUOut and go to FULL; ExtOutValid rises one cycle after the strobe.
REQ-030 SHALL, in FULL with ExtOutReady=1 and CPUWrite=0, complete the transfer and go to EMPTY.
REQ-031 SHALL, in FULL with ExtOutReady=1 and CPUWrite=1, complete the transfer, load the new CPUOut, and stay FULL (back-to-back, no bubble).
REQ-032 SHALL, in FULL with ExtOutReady=0 and CPUWrite=1, drop CPUOut, keep the held word, and set Overflow.
REQ-033 SHALL drive OutBusy = ExtOutValid.
REQ-034 SHALL clear Overflow and Underflow on ErrClear=1; a same-cycle set event SHALL win over clear.
REQ-035 SHALL hold ExtOutData stable while ExtOutValid=1 and ExtOutReady=0.

Reset
REQ-036 SHALL, while reset=1, immediately force: FIFO empty (InCount=0, pointers 0), IOIn=0, InAvail=0, ExtInReady=1 once count reads 0, output FSM EMPTY, ExtOutValid=0, ExtOutData=0, OutBusy=0, Overflow=0, Underflow=0.
REQ-037 SHALL discard all buffered words on reset asserted mid-transfer; no partial word SHALL appear after release.
REQ-038 SHALL ignore all strobes and handshakes while reset=1 and resume on the first rising edge after release.

Verification
REQ-039 Push 0x1111,0x2222,0x3333,0x4444 with CPURead=0 -> InCount=4, ExtInReady=0, IOIn=0x1111; then 4 CPURead cycles -> IOIn 0x2222,0x3333,0x4444,0 in turn, InCount=0.
REQ-040 Fill 3, then 6 cycles of concurrent push/pop with pointer wrap -> InCount stays 3, popped order equals pushed order.
REQ-041 CPUWrite 0xABCD, ExtOutReady=0 -> ExtOutValid=1 next cycle, data 0xABCD held; CPUWrite 0x1234 while stalled -> Overflow=1, data remains 0xABCD.
REQ-042 FULL with 0xABCD, ExtOutReady=1 and CPUWrite 0x5555 same cycle -> 0xABCD accepted, next cycle ExtOutData=0x5555, ExtOutValid=1.
REQ-043 CPURead on empty FIFO -> Underflow=1, InCount=0; ErrClear pulse -> Underflow=0.
REQ-044 Assert reset between clock edges with FIFO at 2 and output FULL -> all outputs at reset values before next edge; after release IOIn=0, ExtOutValid=0.
